// File: rtl/toy_bpu_tage_base_ctrl_pkg.sv
// Shared types, widths and the saturating counter helper for the TAGE base table.
package toy_bpu_tage_base_ctrl_pkg;

  localparam int TAGE_BASE_INDEX_WIDTH = 8;
  localparam int TAGE_BASE_PRED_WIDTH  = 2;

  // Weakly taken: only the MSB set.
  localparam logic [TAGE_BASE_PRED_WIDTH-1:0] TAGE_BASE_INIT_VAL =
    TAGE_BASE_PRED_WIDTH'(1) << (TAGE_BASE_PRED_WIDTH - 1);

  typedef enum logic [1:0] {
    BASE_INIT,
    BASE_IDLE,
    BASE_UPD_WR
  } tage_base_state_t;

  function automatic logic [TAGE_BASE_PRED_WIDTH-1:0] tage_sat_upd(
    input logic [TAGE_BASE_PRED_WIDTH-1:0] ctr,
    input logic                            taken
  );
    if (taken) return (&ctr) ? ctr : ctr + 1'b1;
    else       return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/toy_bpu_tage_base_ctrl.sv
// Single-port arbiter for the TAGE bimodal table: init sweep, prediction reads,
// and read-then-write counter updates with a starvation guard for updates.
//
// state       | meaning
// BASE_INIT   | sweeping INIT_VAL into every entry, all requesters stalled
// BASE_IDLE   | arbitrating prediction reads and update reads
// BASE_UPD_WR | writing back the trained counter read in the previous cycle
module toy_bpu_tage_base_ctrl
  import toy_bpu_tage_base_ctrl_pkg::*;
#(
  parameter int unsigned                     STARVE_MAX = 4,
  parameter logic [TAGE_BASE_PRED_WIDTH-1:0] INIT_VAL   = TAGE_BASE_INIT_VAL
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  output logic                             init_done,
  input  logic                             pred_req_vld,
  output logic                             pred_req_rdy,
  input  logic [TAGE_BASE_INDEX_WIDTH-1:0] pred_req_idx,
  output logic                             pred_rsp_vld,
  output logic [TAGE_BASE_PRED_WIDTH-1:0]  pred_rsp_ctr,
  output logic                             pred_rsp_taken,
  input  logic                             upd_vld,
  output logic                             upd_rdy,
  input  logic [TAGE_BASE_INDEX_WIDTH-1:0] upd_idx,
  input  logic                             upd_taken,
  output logic                             mem_req_vld,
  output logic                             mem_req_wren,
  output logic [TAGE_BASE_INDEX_WIDTH-1:0] mem_req_addr,
  output logic [TAGE_BASE_PRED_WIDTH-1:0]  mem_req_wdata,
  input  logic [TAGE_BASE_PRED_WIDTH-1:0]  mem_ack_rdata
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  tage_base_state_t                 state_q, state_d;
  logic [TAGE_BASE_INDEX_WIDTH-1:0] init_ptr_q;
  logic [SW-1:0]                    starve_q;
  logic                             flush_pend_q;
  logic [TAGE_BASE_INDEX_WIDTH-1:0] upd_idx_q;
  logic                             upd_taken_q;
  logic                             pred_rsp_vld_q;
  logic                             grant_pred, grant_upd;
  logic                             enter_init;

  always_comb begin
    state_d       = state_q;
    grant_pred    = 1'b0;
    grant_upd     = 1'b0;
    mem_req_vld   = 1'b0;
    mem_req_wren  = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      BASE_INIT: begin
        mem_req_vld   = 1'b1;
        mem_req_wren  = 1'b1;
        mem_req_addr  = init_ptr_q;
        mem_req_wdata = INIT_VAL;
        if (!flush && (&init_ptr_q)) state_d = BASE_IDLE;
      end
      BASE_IDLE: begin
        if (flush_pend_q)                           state_d = BASE_INIT;
        else if (upd_vld && starve_q == STARVE_LIM) grant_upd = 1'b1;
        else if (pred_req_vld)                      grant_pred = 1'b1;
        else if (upd_vld)                           grant_upd = 1'b1;
        if (grant_pred) begin
          mem_req_vld  = 1'b1;
          mem_req_addr = pred_req_idx;
        end
        if (grant_upd) begin
          mem_req_vld  = 1'b1;
          mem_req_addr = upd_idx;
          state_d      = BASE_UPD_WR;
        end
      end
      BASE_UPD_WR: begin
        mem_req_vld   = 1'b1;
        mem_req_wren  = 1'b1;
        mem_req_addr  = upd_idx_q;
        mem_req_wdata = tage_sat_upd(mem_ack_rdata, upd_taken_q);
        // A flush seen during the write-back goes straight to the sweep afterwards.
        state_d       = (flush || flush_pend_q) ? BASE_INIT : BASE_IDLE;
      end
      default: state_d = BASE_INIT;
    endcase
  end

  assign enter_init = (state_d == BASE_INIT) && (state_q != BASE_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BASE_INIT;
      init_ptr_q     <= '0;
      starve_q       <= '0;
      flush_pend_q   <= 1'b0;
      upd_idx_q      <= '0;
      upd_taken_q    <= 1'b0;
      pred_rsp_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pred_rsp_vld_q <= grant_pred;
      if (state_q == BASE_INIT) init_ptr_q <= flush ? '0 : init_ptr_q + 1'b1;
      if (enter_init)                             flush_pend_q <= 1'b0;
      else if (flush && state_q != BASE_INIT)     flush_pend_q <= 1'b1;
      if (enter_init || grant_upd)                starve_q <= '0;
      else if (state_q == BASE_IDLE && upd_vld && starve_q != STARVE_LIM)
        starve_q <= starve_q + 1'b1;
      if (grant_upd) begin
        upd_idx_q   <= upd_idx;
        upd_taken_q <= upd_taken;
      end
    end
  end

  assign init_done      = (state_q != BASE_INIT);
  assign pred_req_rdy   = grant_pred;
  assign upd_rdy        = grant_upd;
  assign pred_rsp_vld   = pred_rsp_vld_q;
  assign pred_rsp_ctr   = pred_rsp_vld_q ? mem_ack_rdata : '0;
  assign pred_rsp_taken = pred_rsp_ctr[TAGE_BASE_PRED_WIDTH-1];

endmodule

// File: tb/tb_toy_bpu_tage_base_ctrl.sv
// Bench for toy_bpu_tage_base_ctrl: table stand-in, reference counter array and
// queued expected responses/write-backs, directed scenarios then random traffic.
module tb_toy_bpu_tage_base_ctrl;
  import toy_bpu_tage_base_ctrl_pkg::*;

  localparam int IW       = TAGE_BASE_INDEX_WIDTH;
  localparam int PW       = TAGE_BASE_PRED_WIDTH;
  localparam int DEPTH    = 1 << IW;
  localparam int CTR_MAX  = (1 << PW) - 1;
  localparam int INIT_CTR = 1 << (PW - 1);
  localparam int STARVE   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          init_done;
  logic          pred_req_vld = 1'b0;
  logic          pred_req_rdy;
  logic [IW-1:0] pred_req_idx = '0;
  logic          pred_rsp_vld;
  logic [PW-1:0] pred_rsp_ctr;
  logic          pred_rsp_taken;
  logic          upd_vld = 1'b0;
  logic          upd_rdy;
  logic [IW-1:0] upd_idx = '0;
  logic          upd_taken = 1'b0;
  logic          mem_req_vld, mem_req_wren;
  logic [IW-1:0] mem_req_addr;
  logic [PW-1:0] mem_req_wdata;
  logic [PW-1:0] mem_ack_rdata;

  always #5 clk = ~clk;

  toy_bpu_tage_base_ctrl #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .init_done(init_done),
    .pred_req_vld(pred_req_vld), .pred_req_rdy(pred_req_rdy), .pred_req_idx(pred_req_idx),
    .pred_rsp_vld(pred_rsp_vld), .pred_rsp_ctr(pred_rsp_ctr), .pred_rsp_taken(pred_rsp_taken),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .mem_req_vld(mem_req_vld), .mem_req_wren(mem_req_wren), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_ack_rdata(mem_ack_rdata)
  );

  // Stand-in for the base table: one port, read data registered.
  logic [PW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_req_vld) begin
      if (mem_req_wren) mem[mem_req_addr] <= mem_req_wdata;
      else              mem_ack_rdata <= mem[mem_req_addr];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counters per entry.
  int ref_tbl [DEPTH];
  typedef struct { int addr; int data; } wr_t;
  int  exp_pred[$];
  wr_t exp_wr[$];

  function automatic void ref_init();
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = INIT_CTR;
  endfunction

  // Issue side: every accepted request updates the model and queues its expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      ref_init();
      exp_pred.delete();
      exp_wr.delete();
    end else begin
      if (pred_req_vld && pred_req_rdy) exp_pred.push_back(ref_tbl[pred_req_idx]);
      if (upd_vld && upd_rdy) begin
        int nv;
        nv = upd_taken ? ref_tbl[upd_idx] + 1 : ref_tbl[upd_idx] - 1;
        if (nv > CTR_MAX) nv = CTR_MAX;
        if (nv < 0) nv = 0;
        ref_tbl[upd_idx] = nv;
        exp_wr.push_back('{addr: int'(upd_idx), data: nv});
      end
      if (flush) ref_init();
      if (!init_done) check("rdy_during_init", int'({pred_req_rdy, upd_rdy}), 0);
    end
  end

  // Monitor side: compare whatever the DUT presents against the queue heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pred_rsp_vld) begin
        if (exp_pred.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pred_rsp: got ctr %0d expected no response", pred_rsp_ctr);
        end else begin
          int e;
          e = exp_pred.pop_front();
          check("pred_rsp_ctr", int'(pred_rsp_ctr), e);
          check("pred_rsp_taken", int'(pred_rsp_taken), e >> (PW - 1));
        end
      end
      if (mem_req_vld && mem_req_wren && init_done) begin
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_upd_write: got addr %0d data %0d expected no write",
                   mem_req_addr, mem_req_wdata);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("upd_wr_addr", int'(mem_req_addr), w.addr);
          check("upd_wr_data", int'(mem_req_wdata), w.data);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic wait_rdy(input bit is_upd);
    int n = 0;
    @(negedge clk);
    while (!(is_upd ? upd_rdy : pred_req_rdy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!(is_upd ? upd_rdy : pred_req_rdy)) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: got no rdy after %0d cycles expected a grant (upd=%0d)", n, is_upd);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_upd(input int idx, input bit tk);
    upd_vld = 1'b1; upd_idx = IW'(idx); upd_taken = tk;
    wait_rdy(1'b1);
    upd_vld = 1'b0;
  endtask

  task automatic do_pred(input int idx);
    pred_req_vld = 1'b1; pred_req_idx = IW'(idx);
    wait_rdy(1'b0);
    pred_req_vld = 1'b0;
  endtask

  task automatic count_sweep(input string name);
    int n = 0;
    @(negedge clk);
    while (!init_done && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, DEPTH);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int preds, n;
    ref_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Sweep straight out of reset: one write per cycle, addresses in order.
    for (int k = 0; k < DEPTH; k++) begin
      check("init_wr_en", int'({mem_req_vld, mem_req_wren}), 3);
      check("init_wr_addr", int'(mem_req_addr), k);
      check("init_wr_data", int'(mem_req_wdata), INIT_CTR);
      check("init_done_low", int'(init_done), 0);
      @(negedge clk); #1;
    end
    check("init_done_rise", int'(init_done), 1);
    @(posedge clk); #1;

    // Taken training, saturation, and read-after-update.
    do_upd(5, 1'b1);
    do_pred(5);
    do_upd(5, 1'b1);
    do_pred(5);

    // Not-taken training down to and clamped at zero.
    do_upd(7, 1'b0);
    do_upd(7, 1'b0);
    do_upd(7, 1'b0);
    do_pred(7);

    // Continuous predictions: update must win after STARVE losses, twice.
    pred_req_vld = 1'b1; pred_req_idx = IW'(3);
    upd_vld = 1'b1; upd_idx = IW'(9); upd_taken = 1'b1;
    for (int r = 0; r < 2; r++) begin
      preds = 0; n = 0;
      @(negedge clk);
      while (!upd_rdy && n < 50) begin
        if (pred_req_rdy) preds++;
        n++;
        @(negedge clk);
      end
      check("starve_pred_grants", preds, STARVE);
      check("starve_upd_grant", int'(upd_rdy), 1);
    end
    @(posedge clk); #1;
    pred_req_vld = 1'b0; upd_vld = 1'b0;
    do_pred(9);

    // Flush during the write-back: write lands, then a full sweep with requests held off.
    do_upd(11, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    pred_req_vld = 1'b1; pred_req_idx = IW'(11);
    count_sweep("flush_sweep_len");
    @(posedge clk); #1;
    wait_rdy(1'b0);
    pred_req_vld = 1'b0;

    // Reset on the grant cycle: the update is dropped and the sweep restarts at 0.
    do_upd(13, 1'b1);
    do_upd(13, 1'b1);
    @(posedge clk); #1;
    upd_vld = 1'b1; upd_idx = IW'(13); upd_taken = 1'b1;
    #1;
    check("upd_rdy_before_rst", int'(upd_rdy), 1);
    rst_n = 1'b0;
    #1;
    upd_vld = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("rst_sweep_wr", int'({mem_req_vld, mem_req_wren}), 3);
    check("rst_sweep_addr", int'(mem_req_addr), 0);
    check("rst_init_done", int'(init_done), 0);
    count_sweep("rst_sweep_len");
    @(posedge clk); #1;
    do_pred(13);

    // Random mixed traffic over a small index range to force collisions.
    for (int c = 0; c < 3000; c++) begin
      pred_req_vld = ($urandom_range(0, 1) == 1);
      pred_req_idx = IW'($urandom_range(0, 15));
      upd_vld      = ($urandom_range(0, 9) < 4);
      upd_idx      = IW'($urandom_range(0, 15));
      upd_taken    = ($urandom_range(0, 1) == 1);
      flush        = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    pred_req_vld = 1'b0; upd_vld = 1'b0; flush = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pred_queue_drained", exp_pred.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toy_bpu_tage_base_ctrl.md
# toy_bpu_tage_base_ctrl

Access controller for the TAGE base (bimodal) prediction table, placed between the BPU front end and `toy_bpu_tage_base_table`. It drives the table's single read/write port and shares it between three users: a reset/flush initialisation sweep, prediction reads, and read-modify-write counter updates. Updates are protected from starvation by prediction traffic.

## Interface
- `STARVE_MAX`, default 4: consecutive cycles an update may lose arbitration before it is forced to win.
- `INIT_VAL`, default `TAGE_BASE_INIT_VAL` (weakly taken, `1 << (TAGE_BASE_PRED_WIDTH-1)`): counter value written by the sweep.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: single-cycle pulse requesting a re-initialisation of the whole table.
- `init_done` output 1: high when the table is initialised and serving requests.
- `pred_req_vld` input 1: prediction read request.
- `pred_req_rdy` output 1: prediction request accepted when both `pred_req_vld` and `pred_req_rdy` are high.
- `pred_req_idx` input `TAGE_BASE_INDEX_WIDTH`: prediction index.
- `pred_rsp_vld` output 1: prediction response valid. There is no backpressure on this channel.
- `pred_rsp_ctr` output `TAGE_BASE_PRED_WIDTH`: counter read from the table.
- `pred_rsp_taken` output 1: MSB of `pred_rsp_ctr`.
- `upd_vld` input 1: update request.
- `upd_rdy` output 1: update accepted on the `upd_vld`/`upd_rdy` handshake.
- `upd_idx` input `TAGE_BASE_INDEX_WIDTH`: index of the entry to train.
- `upd_taken` input 1: resolved branch direction.
- `mem_req_vld`, `mem_req_wren`, `mem_req_addr`, `mem_req_wdata`: outputs to the base table request port.
- `mem_ack_rdata` input `TAGE_BASE_PRED_WIDTH`: table read data, valid one cycle after a read.

## Operation
- The FSM has three states: INIT, IDLE and UPD_WR. The table port performs at most one access per cycle.
- INIT:
  - Writes `INIT_VAL` to address `init_ptr`, then increments `init_ptr`.
  - When `init_ptr` is at its all-ones value, the FSM moves to IDLE and `init_ptr` returns to 0.
  - `pred_req_rdy` and `upd_rdy` are held at 0.
- IDLE arbitration, evaluated each cycle:
  - A pending flush moves the FSM to INIT. No grant is given that cycle.
  - If `upd_vld` is high and `starve_cnt == STARVE_MAX`, the update wins.
  - Otherwise, if `pred_req_vld` is high, the prediction wins.
  - Otherwise, if `upd_vld` is high, the update wins.
  - Only the winner sees its `rdy` high.
- Prediction grant: the controller issues a read to `pred_req_idx`. `pred_rsp_vld` goes high the next cycle, with `pred_rsp_ctr = mem_ack_rdata`.
- Update grant:
  - The controller issues a read to `upd_idx` and registers `upd_idx` and `upd_taken`, then moves to UPD_WR.
  - In UPD_WR it writes the saturating next value of `mem_ack_rdata`: +1 if taken, clamped at all-ones; -1 if not taken, clamped at 0.
  - Both rdys are 0 in UPD_WR, and the FSM then returns to IDLE.
  - Read and write are always back to back, so no read can observe a half-done update and no bypass is needed.
- `starve_cnt`:
  - Increments, saturating at `STARVE_MAX`, on each IDLE cycle where `upd_vld` is high and the update is not granted.
  - Clears when an update is granted.
  - Clears on entry to INIT.
- `flush`:
  - Sets `flush_pend`.
  - If it arrives during UPD_WR, the write completes first and INIT is entered on the following cycle.
  - If it arrives during INIT, `init_ptr` restarts at 0.
  - `flush_pend` clears on entry to INIT.
- `init_done` is 0 in INIT and 1 otherwise.

## Timing
- Reset values:
  - FSM in INIT, `init_ptr` = 0, `starve_cnt` = 0, `flush_pend` = 0.
  - `init_done`, `pred_rsp_vld`, `pred_req_rdy` and `upd_rdy` are 0.
  - `pred_rsp_ctr` is 0.
  - `mem_req_vld`, `mem_req_wren`, `mem_req_addr` and `mem_req_wdata` come from the INIT state, so they present write 0 of `INIT_VAL` as soon as reset deasserts.
- Initialisation takes exactly `2^TAGE_BASE_INDEX_WIDTH` cycles. `init_done` rises the cycle after the last write.
- Prediction latency is 1 cycle from handshake to `pred_rsp_vld`. Back-to-back predictions are accepted every cycle.
- An update occupies the port for 2 cycles: read, then write. A prediction issued right after an update to the same index sees the new value.
- `rdy` signals are combinational from the current state, `starve_cnt`, `flush_pend` and the request `vld`s. Requesters must not make `vld` depend on `rdy`.
- All mem outputs are combinational from the state and the granted request.
- Asserting reset mid-update drops the update. The table is then re-swept.

## Structure
- `toy_pack` additions:
  - `TAGE_BASE_INIT_VAL`.
  - `typedef enum logic [1:0] {BASE_INIT, BASE_IDLE, BASE_UPD_WR} tage_base_state_t`.
  - Saturating counter function `tage_sat_upd(ctr, taken)`, shared with the tagged-table controllers.
- No sub-module is needed. `toy_bpu_tage_base_table` is instantiated alongside this block by the BPU top.

## Test plan
- Reset, then hold idle with width 2 and 256 entries → 256 consecutive writes of value 2 to addresses 0..255, with `init_done` rising on cycle 257.
- Update idx 5 with taken=1 (table holds 2), then predict idx 5 → UPD_WR writes 3, and the following prediction returns ctr=3, taken=1. A further taken update writes 3 (saturated).
- Update idx 7 with taken=0, starting from value 0 → write of 0. A prediction immediately after returns 0.
- `pred_req_vld` held high continuously with `upd_vld` high → prediction granted for 4 cycles, update granted on the 5th cycle, `starve_cnt` back to 0.
- `flush` pulsed while in UPD_WR → the write completes, then a full 256-cycle sweep runs. `init_done` is low during the sweep and no rdy is asserted.
- `rst_n` asserted on the cycle an update is granted → no UPD_WR write occurs, and the sweep restarts at address 0.
